mem_responder: RTL and testbench

Memory-side responder for the load/store port of the pipelined RISC core. It accepts one word-addressed read or write request at a time over a valid/ready handshake and holds it for a programmable number of wait states. It then performs the access on an internal word array and returns a response over a second valid/ready handshake. The block sits between the core's execute stage and data storage, and models a slow memory so the core's stall logic can be exercised.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_array.sv | 35 +++
 rtl/mem_responder.sv | 115 +++++++++++
 tb/tb_mem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default parameters for the slow-memory responder.
// The request struct is sized by the package defaults.
package mem_pkg;

    localparam int unsigned DefDataWidth = 32;
    localparam int unsigned DefAddrWidth = 10;
    localparam int unsigned DefDepth     = 256;
    localparam int unsigned DefLatency   = 2;
    localparam int unsigned CntWidth     = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    typedef struct packed {
        logic                        write;
        logic [DefAddrWidth-1:0]     addr;
        logic [DefDataWidth-1:0]     wdata;
        logic [DefDataWidth/8-1:0]   wstrb;
    } req_t;

endpackage

// File: rtl/mem_array.sv
// Word storage with asynchronous clear, byte-strobed synchronous write
// and combinational read on a shared address.
module mem_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [IDX_WIDTH-1:0]    addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wstrb[b]) begin
                    mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Load/store responder modelling a slow memory: one request at a time,
// LATENCY wait states, then a held response until the requester takes it.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned LATENCY    = DefLatency
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err
);

    localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CntWidth-1:0] CntLoad =
        (LATENCY == 0) ? '0 : CntWidth'(LATENCY - 1);

    state_e                state_q, state_d;
    req_t                  req_q, cur;
    logic [CntWidth-1:0]   cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q, arr_rdata;
    logic                  err_q;
    logic                  accept, rsp_done, enter_resp, in_range, arr_we;

    // With zero latency the access happens on the accept edge, so it must
    // use the live request rather than the not-yet-captured copy.
    always_comb begin
        cur = req_q;
        if (state_q == StIdle) begin
            cur = '{write: req_write, addr: req_addr, wdata: req_wdata, wstrb: req_wstrb};
        end
    end

    assign accept     = (state_q == StIdle) && req_valid;
    assign rsp_done   = (state_q == StResp) && rsp_ready;
    assign enter_resp = (state_d == StResp) && (state_q != StResp);
    assign in_range   = 32'(cur.addr) < DEPTH;
    assign arr_we     = enter_resp && cur.write && in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (req_valid) state_d = (LATENCY == 0) ? StResp : StWait;
            StWait: if (cnt_q == '0) state_d = StResp;
            StResp: if (rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready = (state_q == StIdle);
        rsp_valid = (state_q == StResp);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                req_q <= cur;
                cnt_q <= CntLoad;
            end else if ((state_q == StWait) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end

            if (enter_resp) begin
                rdata_q <= (!cur.write && in_range) ? arr_rdata : '0;
                err_q   <= !in_range;
            end else if (rsp_done) begin
                rdata_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_WIDTH  (IdxWidth)
    ) u_mem_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .addr  (cur.addr[IdxWidth-1:0]),
        .wdata (cur.wdata),
        .wstrb (cur.wstrb),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a LATENCY=2 instance and a LATENCY=0
// instance sharing clock and reset.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        req_valid, req_ready, req_write;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0, req_ready0, req_write0;
    logic [9:0]  req_addr0;
    logic [31:0] req_wdata0;
    logic [3:0]  req_wstrb0;
    logic        rsp_valid0, rsp_ready0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    mem_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10),
        .DEPTH      (256),
        .LATENCY    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    mem_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10),
        .DEPTH      (256),
        .LATENCY    (0)
    ) dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid0),
        .req_ready (req_ready0),
        .req_write (req_write0),
        .req_addr  (req_addr0),
        .req_wdata (req_wdata0),
        .req_wstrb (req_wstrb0),
        .rsp_valid (rsp_valid0),
        .rsp_ready (rsp_ready0),
        .rsp_rdata (rsp_rdata0),
        .rsp_err   (rsp_err0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 32) begin
            tick();
            lat++;
        end
    endtask

    task automatic take_rsp(output logic [31:0] d, output logic e);
        d = rsp_rdata;
        e = rsp_err;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          lat;
        logic [31:0] d;
        logic        e;

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b0;
        req_valid0 = 1'b0; req_write0 = 1'b0; req_addr0 = '0; req_wdata0 = '0;
        req_wstrb0 = '0; rsp_ready0 = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);

        // Load of a cleared word; valid seen LATENCY edges after acceptance.
        issue(1'b0, 10'd5, 32'd0, 4'h0);
        check("load5_busy", 32'(req_ready), 32'd0);
        wait_rsp(lat);
        check("load5_latency", 32'(lat), 32'd2);
        take_rsp(d, e);
        check("load5_rdata", d, 32'd0);
        check("load5_err", 32'(e), 32'd0);
        check("load5_idle_ready", 32'(req_ready), 32'd1);
        check("load5_valid_cleared", 32'(rsp_valid), 32'd0);

        // Full store then partial byte store, then read back merged word.
        issue(1'b1, 10'd7, 32'hDEADBEEF, 4'b1111);
        wait_rsp(lat);
        take_rsp(d, e);
        check("st7_rdata", d, 32'd0);
        check("st7_err", 32'(e), 32'd0);
        issue(1'b1, 10'd7, 32'h000000AA, 4'b0001);
        wait_rsp(lat);
        take_rsp(d, e);
        issue(1'b0, 10'd7, 32'd0, 4'h0);
        wait_rsp(lat);
        take_rsp(d, e);
        check("ld7_merged", d, 32'hDEADBEAA);

        // Out-of-range accesses never alias onto addr % DEPTH.
        issue(1'b0, 10'd300, 32'd0, 4'h0);
        wait_rsp(lat);
        take_rsp(d, e);
        check("ld300_err", 32'(e), 32'd1);
        check("ld300_rdata", d, 32'd0);
        issue(1'b1, 10'd300, 32'hFFFFFFFF, 4'b1111);
        wait_rsp(lat);
        take_rsp(d, e);
        check("st300_err", 32'(e), 32'd1);
        issue(1'b0, 10'd44, 32'd0, 4'h0);
        wait_rsp(lat);
        take_rsp(d, e);
        check("ld44_rdata", d, 32'd0);
        check("ld44_err", 32'(e), 32'd0);

        // Zero-strobe store is acknowledged but changes nothing.
        issue(1'b1, 10'd7, 32'h00000000, 4'b0000);
        wait_rsp(lat);
        take_rsp(d, e);
        check("st7_nostrb_err", 32'(e), 32'd0);

        // Backpressure: response held stable for 5 cycles.
        issue(1'b0, 10'd7, 32'd0, 4'h0);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_rdata", rsp_rdata, 32'hDEADBEAA);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("stall_release_ready", 32'(req_ready), 32'd1);
        check("stall_release_valid", 32'(rsp_valid), 32'd0);
        issue(1'b0, 10'd5, 32'd0, 4'h0);
        check("next_req_accepted", 32'(req_ready), 32'd0);
        wait_rsp(lat);
        take_rsp(d, e);
        check("next_req_rdata", d, 32'd0);

        // Reset during WAIT discards the pending store.
        issue(1'b1, 10'd3, 32'h00001234, 4'b1111);
        tick();
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_rsp_rdata", rsp_rdata, 32'd0);
        check("midrst_rsp_err", 32'(rsp_err), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        issue(1'b0, 10'd3, 32'd0, 4'h0);
        wait_rsp(lat);
        take_rsp(d, e);
        check("ld3_after_rst", d, 32'd0);

        // LATENCY=0 instance: back-to-back requests, rsp_ready tied high.
        req_valid0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            logic [31:0] exp_rdata;
            case (k)
                0: begin req_write0 = 1'b1; req_addr0 = 10'd1; req_wdata0 = 32'h11111111;
                         req_wstrb0 = 4'b1111; exp_rdata = 32'd0; end
                1: begin req_write0 = 1'b1; req_addr0 = 10'd2; req_wdata0 = 32'h55667722;
                         req_wstrb0 = 4'b0001; exp_rdata = 32'd0; end
                2: begin req_write0 = 1'b0; req_addr0 = 10'd1; req_wdata0 = 32'd0;
                         req_wstrb0 = 4'b0000; exp_rdata = 32'h11111111; end
                default: begin req_write0 = 1'b0; req_addr0 = 10'd2; req_wdata0 = 32'd0;
                         req_wstrb0 = 4'b0000; exp_rdata = 32'h00000022; end
            endcase
            tick();
            check("l0_rsp_valid", 32'(rsp_valid0), 32'd1);
            check("l0_req_ready_busy", 32'(req_ready0), 32'd0);
            check("l0_rdata", rsp_rdata0, exp_rdata);
            tick();
            check("l0_rsp_done", 32'(rsp_valid0), 32'd0);
            check("l0_req_ready_idle", 32'(req_ready0), 32'd1);
        end
        req_valid0 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
